// File: rtl/pong_ball.sv
// pong_ball: ball position, paddle collisions, serve/miss FSM and scoring.
// Define PONG_AUTOSERVE_EN to also leave IDLE on the first frame tick.
module pong_ball #(
   parameter int unsigned SPEED        = 2,
   parameter int unsigned STEP_DIV     = 1,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned PADDLE_H     = 80
) (
   input  logic       px_clk,
   input  logic       reset_ni,
   input  logic [9:0] x_i,
   input  logic [9:0] y_i,
   input  logic       serve_i,
   input  logic [9:0] paddle_l_y_i,
   input  logic [9:0] paddle_r_y_i,
   output logic [9:0] ball_x_o,
   output logic [9:0] ball_y_o,
   output logic       dir_x_o,
   output logic       dir_y_o,
   output logic [1:0] state_o,
   output logic [3:0] score_l_o,
   output logic [3:0] score_r_o,
   output logic       miss_o
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SERVE = 2'd1,
      S_PLAY  = 2'd2,
      S_MISS  = 2'd3
   } state_t;

   localparam logic [9:0]  SPD10      = 10'(SPEED);
   localparam logic [10:0] SPD11      = 11'(SPEED);
   localparam logic [10:0] PH11       = 11'(PADDLE_H);
   localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
   localparam logic [7:0]  STEP_LAST  = 8'(STEP_DIV - 1);
   localparam logic [9:0]  HOME_X     = 10'd310;
   localparam logic [9:0]  HOME_Y     = 10'd225;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_tick;
   logic [7:0]  r_frame_cnt;
   logic [7:0]  w_frame_nxt;
   logic [7:0]  r_step_cnt;
   logic [7:0]  w_step_nxt;
   logic [9:0]  r_ball_x;
   logic [9:0]  w_ball_x_nxt;
   logic [9:0]  r_ball_y;
   logic [9:0]  w_ball_y_nxt;
   logic        r_dir_x;
   logic        w_dir_x_nxt;
   logic        r_dir_y;
   logic        w_dir_y_nxt;
   logic [3:0]  r_score_l;
   logic [3:0]  w_score_l_nxt;
   logic [3:0]  r_score_r;
   logic [3:0]  w_score_r_nxt;
   logic        r_loser_r;
   logic        w_loser_r_nxt;
   logic        w_tick_in;
   logic        w_auto;
   logic [10:0] w_bx;
   logic [10:0] w_by;
   logic [10:0] w_pl;
   logic [10:0] w_pr;
   logic        w_ovl_l;
   logic        w_ovl_r;
   logic        w_hit_l;
   logic        w_hit_r;
   logic        w_out_l;
   logic        w_out_r;

   assign w_tick_in = (x_i == 10'd0) && (y_i == 10'd480);

`ifdef PONG_AUTOSERVE_EN
   assign w_auto = r_tick;
`else
   assign w_auto = 1'b0;
`endif

   // 11-bit views keep every sum and difference below free of wrap
   assign w_bx = {1'b0, r_ball_x};
   assign w_by = {1'b0, r_ball_y};
   assign w_pl = {1'b0, paddle_l_y_i};
   assign w_pr = {1'b0, paddle_r_y_i};

   assign w_ovl_l = (w_by + 11'd30 > w_pl) && (w_by < w_pl + PH11);
   assign w_ovl_r = (w_by + 11'd30 > w_pr) && (w_by < w_pr + PH11);
   assign w_hit_l = (w_bx >= 11'd50) && (w_bx < 11'd50 + SPD11)
                    && w_ovl_l;
   assign w_hit_r = (w_bx + 11'd20 <= 11'd590)
                    && (w_bx + 11'd20 > 11'd590 - SPD11) && w_ovl_r;
   assign w_out_l = w_bx < SPD11;
   assign w_out_r = w_bx > 11'd620 - SPD11;

   always_ff @(posedge px_clk or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state     <= S_IDLE;
         r_tick      <= 1'b0;
         r_frame_cnt <= 8'd0;
         r_step_cnt  <= 8'd0;
         r_ball_x    <= HOME_X;
         r_ball_y    <= HOME_Y;
         r_dir_x     <= 1'b1;
         r_dir_y     <= 1'b1;
         r_score_l   <= 4'd0;
         r_score_r   <= 4'd0;
         r_loser_r   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_tick      <= w_tick_in;
         r_frame_cnt <= w_frame_nxt;
         r_step_cnt  <= w_step_nxt;
         r_ball_x    <= w_ball_x_nxt;
         r_ball_y    <= w_ball_y_nxt;
         r_dir_x     <= w_dir_x_nxt;
         r_dir_y     <= w_dir_y_nxt;
         r_score_l   <= w_score_l_nxt;
         r_score_r   <= w_score_r_nxt;
         r_loser_r   <= w_loser_r_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_frame_nxt   = r_frame_cnt;
      w_step_nxt    = r_step_cnt;
      w_ball_x_nxt  = r_ball_x;
      w_ball_y_nxt  = r_ball_y;
      w_dir_x_nxt   = r_dir_x;
      w_dir_y_nxt   = r_dir_y;
      w_score_l_nxt = r_score_l;
      w_score_r_nxt = r_score_r;
      w_loser_r_nxt = r_loser_r;
      unique case (r_state)
         S_IDLE: begin
            w_ball_x_nxt = HOME_X;
            w_ball_y_nxt = HOME_Y;
            if (serve_i || w_auto) begin
               w_state_nxt = S_SERVE;
               w_frame_nxt = 8'd0;
            end
         end
         S_SERVE: begin
            if (r_tick) begin
               if (r_frame_cnt == SERVE_LAST) begin
                  w_state_nxt = S_PLAY;
                  w_step_nxt  = 8'd0;
               end else begin
                  w_frame_nxt = r_frame_cnt + 8'd1;
               end
            end
         end
         S_PLAY: begin
            if (r_tick && (r_step_cnt != STEP_LAST)) begin
               w_step_nxt = r_step_cnt + 8'd1;
            end else if (r_tick) begin
               w_step_nxt = 8'd0;
               if (r_dir_y) begin
                  if (w_by + SPD11 >= 11'd450) begin
                     w_ball_y_nxt = 10'd450;
                     w_dir_y_nxt  = 1'b0;
                  end else begin
                     w_ball_y_nxt = r_ball_y + SPD10;
                  end
               end else if (w_by < SPD11) begin
                  w_ball_y_nxt = 10'd0;
                  w_dir_y_nxt  = 1'b1;
               end else begin
                  w_ball_y_nxt = r_ball_y - SPD10;
               end
               if (!r_dir_x) begin
                  if (w_hit_l) begin
                     w_ball_x_nxt = 10'd50;
                     w_dir_x_nxt  = 1'b1;
                  end else if (w_out_l) begin
                     w_state_nxt   = S_MISS;
                     w_loser_r_nxt = 1'b0;
                  end else begin
                     w_ball_x_nxt = r_ball_x - SPD10;
                  end
               end else begin
                  if (w_hit_r) begin
                     w_ball_x_nxt = 10'd570;
                     w_dir_x_nxt  = 1'b0;
                  end else if (w_out_r) begin
                     w_state_nxt   = S_MISS;
                     w_loser_r_nxt = 1'b1;
                  end else begin
                     w_ball_x_nxt = r_ball_x + SPD10;
                  end
               end
            end
         end
         S_MISS: begin
            w_state_nxt  = S_IDLE;
            w_ball_x_nxt = HOME_X;
            w_ball_y_nxt = HOME_Y;
            if (r_loser_r) begin
               w_dir_x_nxt = 1'b1;
               if (r_score_l != 4'd15)
                  w_score_l_nxt = r_score_l + 4'd1;
            end else begin
               w_dir_x_nxt = 1'b0;
               if (r_score_r != 4'd15)
                  w_score_r_nxt = r_score_r + 4'd1;
            end
         end
      endcase
   end

   assign ball_x_o  = r_ball_x;
   assign ball_y_o  = r_ball_y;
   assign dir_x_o   = r_dir_x;
   assign dir_y_o   = r_dir_y;
   assign state_o   = r_state;
   assign score_l_o = r_score_l;
   assign score_r_o = r_score_r;
   assign miss_o    = (r_state == S_MISS);

endmodule

// File: tb/tb_pong_ball.sv
// tb_pong_ball: random play against an integer rules model of pong_ball,
// plus directed serve, miss, saturation and async reset checks.
module tb_pong_ball;
   localparam int SPD = 2;
   localparam int SF  = 60;
   localparam int SD  = 1;
   localparam int PH  = 80;
`ifdef PONG_AUTOSERVE_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       px_clk = 1'b0;
   logic       reset_ni = 1'b0;
   logic [9:0] x_i = 10'd1;
   logic [9:0] y_i = 10'd0;
   logic       serve_i = 1'b0;
   logic [9:0] paddle_l_y_i = 10'd0;
   logic [9:0] paddle_r_y_i = 10'd0;
   logic [9:0] ball_x_o;
   logic [9:0] ball_y_o;
   logic       dir_x_o;
   logic       dir_y_o;
   logic [1:0] state_o;
   logic [3:0] score_l_o;
   logic [3:0] score_r_o;
   logic       miss_o;

   int total = 0;
   int bad = 0;

   pong_ball dut (
      .px_clk       (px_clk),
      .reset_ni     (reset_ni),
      .x_i          (x_i),
      .y_i          (y_i),
      .serve_i      (serve_i),
      .paddle_l_y_i (paddle_l_y_i),
      .paddle_r_y_i (paddle_r_y_i),
      .ball_x_o     (ball_x_o),
      .ball_y_o     (ball_y_o),
      .dir_x_o      (dir_x_o),
      .dir_y_o      (dir_y_o),
      .state_o      (state_o),
      .score_l_o    (score_l_o),
      .score_r_o    (score_r_o),
      .miss_o       (miss_o)
   );

   always #5 px_clk = ~px_clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // rules model: 0 idle, 1 serve, 2 play, 3 miss
   int m_st = 0;
   int m_bx = 310;
   int m_by = 225;
   int m_dx = 1;
   int m_dy = 1;
   int m_sl = 0;
   int m_sr = 0;
   int m_ticks = 0;
   int m_loser_r = 0;
   bit m_tk = 1'b0;

   always @(posedge px_clk or negedge reset_ni) begin
      if (!reset_ni) begin
         m_st = 0; m_bx = 310; m_by = 225; m_dx = 1; m_dy = 1;
         m_sl = 0; m_sr = 0; m_ticks = 0; m_loser_r = 0; m_tk = 0;
      end else begin
         bit t;
         int oy;
         int pl;
         int pr;
         t = m_tk;
         m_tk = (x_i == 10'd0) && (y_i == 10'd480);
         pl = int'(paddle_l_y_i);
         pr = int'(paddle_r_y_i);
         case (m_st)
            0: begin
               m_bx = 310; m_by = 225;
               if (serve_i || (AUTO && t)) begin
                  m_st = 1; m_ticks = 0;
               end
            end
            1: if (t) begin
               m_ticks++;
               if (m_ticks == SF) begin
                  m_st = 2; m_ticks = 0;
               end
            end
            2: if (t) begin
               m_ticks++;
               if (m_ticks == SD) begin
                  m_ticks = 0;
                  oy = m_by;
                  if (m_dy == 1) begin
                     if (oy + SPD >= 450) begin m_by = 450; m_dy = 0; end
                     else m_by = oy + SPD;
                  end else if (oy < SPD) begin
                     m_by = 0; m_dy = 1;
                  end else m_by = oy - SPD;
                  if (m_dx == 0) begin
                     if (m_bx >= 50 && m_bx < 50 + SPD &&
                         oy + 30 > pl && oy < pl + PH) begin
                        m_bx = 50; m_dx = 1;
                     end else if (m_bx < SPD) begin
                        m_st = 3; m_loser_r = 0;
                     end else m_bx = m_bx - SPD;
                  end else begin
                     if (m_bx + 20 <= 590 && m_bx + 20 > 590 - SPD &&
                         oy + 30 > pr && oy < pr + PH) begin
                        m_bx = 570; m_dx = 0;
                     end else if (m_bx > 620 - SPD) begin
                        m_st = 3; m_loser_r = 1;
                     end else m_bx = m_bx + SPD;
                  end
               end
            end
            default: begin
               if (m_loser_r == 1) begin
                  m_sl = (m_sl < 15) ? m_sl + 1 : 15; m_dx = 1;
               end else begin
                  m_sr = (m_sr < 15) ? m_sr + 1 : 15; m_dx = 0;
               end
               m_st = 0; m_bx = 310; m_by = 225;
            end
         endcase
      end
   end

   always @(negedge px_clk) begin
      if (reset_ni && bad < 100) begin
         chk("state", int'(state_o), m_st);
         chk("ball_x", int'(ball_x_o), m_bx);
         chk("ball_y", int'(ball_y_o), m_by);
         chk("dir_x", int'(dir_x_o), m_dx);
         chk("dir_y", int'(dir_y_o), m_dy);
         chk("score_l", int'(score_l_o), m_sl);
         chk("score_r", int'(score_r_o), m_sr);
         chk("miss", int'(miss_o), int'(m_st == 3));
      end
   end

   task automatic tick();
      x_i = 10'd0; y_i = 10'd480;
      @(negedge px_clk);
      x_i = 10'd5; y_i = 10'd100;
      @(negedge px_clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, int'(state_o), 0);
      chk({tag, "_bx"}, int'(ball_x_o), 310);
      chk({tag, "_by"}, int'(ball_y_o), 225);
      chk({tag, "_dx"}, int'(dir_x_o), 1);
      chk({tag, "_dy"}, int'(dir_y_o), 1);
      chk({tag, "_sl"}, int'(score_l_o), 0);
      chk({tag, "_sr"}, int'(score_r_o), 0);
      chk({tag, "_miss"}, int'(miss_o), 0);
   endtask

   initial begin
      int n;
      int p;
      repeat (3) @(negedge px_clk);
      chk_reset_vals("rst");
      reset_ni = 1'b1;

      // serve timing
      @(negedge px_clk); serve_i = 1'b1;
      @(negedge px_clk); serve_i = 1'b0;
      chk("serve_state", int'(state_o), 1);
      repeat (SF) tick();
      chk("play_after_60", int'(state_o), 2);
      tick();
      chk("first_step_x", int'(ball_x_o), 312);
      chk("first_step_y", int'(ball_y_o), 227);

      // unreachable paddles: right side loses every rally
      paddle_l_y_i = 10'd1000;
      paddle_r_y_i = 10'd1000;
      serve_i = 1'b1;
      for (int r = 0; r < 17; r++) begin
         n = 0;
         while (!miss_o && n < 400) begin
            tick();
            n++;
         end
         chk("miss_seen", int'(miss_o), 1);
         @(negedge px_clk);
         chk("miss_one_cycle", int'(miss_o), 0);
         chk("miss_idle", int'(state_o), 0);
         chk("miss_home_x", int'(ball_x_o), 310);
         chk("miss_home_y", int'(ball_y_o), 225);
         if (r == 0) chk("first_point", int'(score_l_o), 1);
         if (r == 16) chk("score_sat", int'(score_l_o), 15);
      end
      chk("score_r_zero", int'(score_r_o), 0);

      // random rallies with paddles mostly tracking the ball
      for (int c = 0; c < 6000; c++) begin
         serve_i = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 2) == 0) begin
            x_i = 10'd0; y_i = 10'd480;
         end else begin
            x_i = 10'($urandom_range(1, 799));
            y_i = 10'($urandom_range(0, 524));
         end
         p = m_by + 15 - int'($urandom_range(0, 90));
         if ($urandom_range(0, 3) == 0) p = int'($urandom_range(0, 1023));
         paddle_r_y_i = 10'((p < 0) ? 0 : p);
         p = m_by + 15 - int'($urandom_range(0, 90));
         if ($urandom_range(0, 3) == 0) p = int'($urandom_range(0, 1023));
         paddle_l_y_i = 10'((p < 0) ? 0 : p);
         @(negedge px_clk);
      end

      // async reset in the middle of play
      x_i = 10'd5; y_i = 10'd100;
      serve_i = 1'b1;
      n = 0;
      while (m_st != 2 && n < 300) begin
         tick();
         n++;
      end
      serve_i = 1'b0;
      tick();
      chk("play_before_rst", int'(state_o), 2);
      #2 reset_ni = 1'b0;
      #1 chk_reset_vals("async_rst");
      @(negedge px_clk);
      repeat (2) @(negedge px_clk);
      reset_ni = 1'b1;
      tick();
      chk("post_rst_tick", int'(state_o), AUTO ? 1 : 0);
      repeat (3) @(negedge px_clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pong_ball.md
PONG_BALL -- requirements
Module: pong_ball

Interface
REQ-001 Parameter SPEED, default 2: pixels moved per axis per motion step.
REQ-002 Parameter STEP_DIV, default 1: frame ticks per motion step (1..255).
REQ-003 Parameter SERVE_FRAMES, default 60: frame ticks spent in SERVE before PLAY.
REQ-004 Parameter PADDLE_H, default 80: paddle height in lines.
REQ-005 Clock px_clk, input, 1 bit: pixel clock. All state is updated on the rising edge.
REQ-006 Reset reset_ni, input, 1 bit: asynchronous, active-low.
REQ-007 x_i, input, 10 bits: current scan column from the VGA timing stage.
REQ-008 y_i, input, 10 bits: current scan line.
REQ-009 serve_i, input, 1 bit: level, sampled every cycle, requests a serve.
REQ-010 paddle_l_y_i, input, 10 bits: top line of the left paddle.
REQ-011 paddle_r_y_i, input, 10 bits: top line of the right paddle.
REQ-012 ball_x_o and ball_y_o, outputs, 10 bits each: top-left corner of the ball, which is 20x30 pixels.
REQ-013 dir_x_o and dir_y_o, outputs, 1 bit each: 1 means right or down, 0 means left or up.
REQ-014 state_o, output, 2 bits: IDLE=0, SERVE=1, PLAY=2, MISS=3.
REQ-015 score_l_o and score_r_o, outputs, 4 bits each: player scores.
REQ-016 miss_o, output, 1 bit: one-cycle pulse when a point is lost.

Function
REQ-017 A frame tick is asserted for exactly one cycle, in the cycle after x_i==0 and y_i==480 are sampled.
REQ-018 IDLE behaviour:
- the ball is held at (310,225);
- on serve_i=1 the block goes to SERVE and clears the frame counter.
REQ-019 SERVE behaviour:
- the block counts frame ticks;
- on tick number SERVE_FRAMES it goes to PLAY and clears the step divider;
- serve_i is ignored.
REQ-020 PLAY behaviour:
- on every STEP_DIV-th frame tick, each axis is updated once, according to REQ-021..REQ-024;
- the two axes are evaluated independently in the same cycle.
REQ-021 Y axis:
- moving down and ball_y+SPEED>=450: ball_y=450, dir_y=0;
- moving up and ball_y<SPEED: ball_y=0, dir_y=1;
- otherwise ball_y moves by ±SPEED.
REQ-022 Left side (moving left):
- a hit occurs when ball_x>=50, ball_x<50+SPEED, and the ball overlaps the paddle vertically (ball_y+30>paddle_l_y_i and ball_y<paddle_l_y_i+PADDLE_H);
- on a hit, ball_x=50 and dir_x=1;
- otherwise, if ball_x<SPEED the block goes to MISS with loser=left;
- otherwise ball_x decreases by SPEED.
REQ-023 Right side (moving right):
- a hit occurs when ball_x+20<=590, ball_x+20>590-SPEED, and the same overlap test passes against paddle_r_y_i;
- on a hit, ball_x=570 and dir_x=0;
- otherwise, if ball_x>620-SPEED the block goes to MISS with loser=right;
- otherwise ball_x increases by SPEED.
REQ-024 All overlap and limit comparisons use 11-bit unsigned arithmetic, so no term wraps.
REQ-025 MISS behaviour, which lasts exactly one cycle:
- miss_o=1;
- the opposing score increments, saturating at 15;
- dir_x is set to point toward the loser;
- the next state is IDLE.
REQ-026 Serve requests:
- serve_i is ignored in PLAY and MISS;
- a serve_i held high through IDLE re-serves immediately.
REQ-027 If a frame tick coincides with a state transition, the tick is consumed by the old state only.

Reset
REQ-028 While reset_ni=0, all outputs take these values, including when reset is asserted mid-operation:
- state IDLE;
- ball at (310,225);
- dir_x=1, dir_y=1;
- both scores 0;
- miss_o=0;
- frame and step counters 0.
REQ-029 Reset release takes effect on the first px_clk edge after reset_ni rises.

Configuration
REQ-030 Macro PONG_AUTOSERVE_EN:
- when defined, IDLE also goes to SERVE on the first frame tick, so play restarts with no serve_i;
- when undefined, only serve_i leaves IDLE.

Verification
REQ-031 Serve timing (defaults): reset, then serve_i pulse, then 60 frame ticks -> state_o=2; the next tick moves the ball to (312,227).
REQ-032 Top bounce: ball_y=1, dir_y=0, one step -> ball_y=0, dir_y=1.
REQ-033 Right paddle hit: ball_x=569, ball_y=220, paddle_r_y_i=200, dir_x=1, one step -> ball_x=570, dir_x=0.
REQ-034 Right miss: paddle_r_y_i=0, ball_y=300, ball moving right -> when ball_x exceeds 618:
- miss_o is high for one cycle;
- score_l_o goes from 0 to 1;
- the ball returns to (310,225) in IDLE.
REQ-035 Score saturation: score_l_o=15, then a further right miss -> score stays 15.
REQ-036 Reset mid-PLAY, plus auto-serve:
- reset_ni low mid-PLAY -> all REQ-028 values appear immediately, with no clock edge needed;
- with PONG_AUTOSERVE_EN, the first frame tick after reset -> state_o=1.
